// File: rtl/clk_meter_pkg.sv
// Shared types for the clock meter: status encoding, FSM states, default counter width.
package clk_meter_pkg;

  localparam int CNT_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MEASURING = 3'd1,
    ST_LOCKED    = 3'd2,
    ST_SLOW      = 3'd3,
    ST_FAST      = 3'd4,
    ST_TIMEOUT   = 3'd5,
    ST_OVERFLOW  = 3'd6
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/clk_meter_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, followed by a rising-edge pulse.
module clk_meter_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign rise_o = sync_q[STAGES-1] & ~dly_q;

endmodule

// File: rtl/clk_meter.sv
// Clock meter: counts ref_clk cycles over N periods of meas_in and grades the result.
// Optional min/max single-period tracking when CLK_METER_MINMAX_EN is defined.
//
// state   | meaning
// S_IDLE  | disabled; status shows the last result
// S_ARM   | settings captured, waiting for the first meas_in rise
// S_COUNT | counting ref cycles, counting meas_in rises
// S_DONE  | one cycle: grade the captured count, publish result
module clk_meter
  import clk_meter_pkg::*;
#(
  parameter int CNT_W          = CNT_W_DEF,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic             ref_clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             meas_in,
  input  logic [7:0]       periods,
  input  logic [CNT_W-1:0] expected,
  input  logic [15:0]      tolerance,
  output logic [CNT_W-1:0] measured,
  output logic             valid,
  output logic [2:0]       status
`ifdef CLK_METER_MINMAX_EN
  ,
  output logic [CNT_W-1:0] min_period,
  output logic [CNT_W-1:0] max_period
`endif
);

  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       edges_q, edges_d, edges_nxt;
  logic [7:0]       per_q, per_d;
  logic [CNT_W-1:0] exp_q, exp_d;
  logic [CNT_W-1:0] tol_q, tol_d;
  logic [TO_W-1:0]  idle_q, idle_d;
  logic [CNT_W-1:0] meas_q, meas_d;
  logic             valid_q, valid_d;
  status_e          status_q, status_d;
  status_e          last_res_q, last_res_d;

  logic    rise;
  logic    idle_run, idle_tc;
  logic    arm_load, result_ev;
  status_e result, grade;

  logic [CNT_W:0] m_x, e_x, t_x, hi_x, mt_x;

  clk_meter_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (ref_clk),
    .reset   (reset),
    .async_i (meas_in),
    .rise_o  (rise)
  );

  // One extra bit keeps expected+tolerance from wrapping.
  assign m_x  = {1'b0, meas_q};
  assign e_x  = {1'b0, exp_q};
  assign t_x  = {1'b0, tol_q};
  assign hi_x = e_x + t_x;
  assign mt_x = m_x + t_x;

  always_comb begin
    grade = ST_LOCKED;
    if (m_x > hi_x)     grade = ST_SLOW;
    else if (mt_x < e_x) grade = ST_FAST;
  end

  assign idle_run  = (state_q == S_ARM) || (state_q == S_COUNT);
  assign idle_tc   = idle_run && !rise && (idle_q == '0);
  assign edges_nxt = edges_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    edges_d    = edges_q;
    per_d      = per_q;
    exp_d      = exp_q;
    tol_d      = tol_q;
    meas_d     = meas_q;
    valid_d    = 1'b0;
    status_d   = status_q;
    last_res_d = last_res_q;
    arm_load   = 1'b0;
    result_ev  = 1'b0;
    result     = ST_IDLE;

    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d  = S_ARM;
          arm_load = 1'b1;
        end
      end
      S_ARM: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (rise) begin
          count_d = CNT_W'(1);
          edges_d = '0;
          state_d = S_COUNT;
        end else if (idle_tc) begin
          meas_d    = '0;
          result_ev = 1'b1;
          result    = ST_TIMEOUT;
          arm_load  = 1'b1;
        end
      end
      S_COUNT: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (count_q == '1) begin
          meas_d    = '1;
          result_ev = 1'b1;
          result    = ST_OVERFLOW;
          state_d   = S_ARM;
          arm_load  = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
          if (rise) begin
            edges_d = edges_nxt;
            if (edges_nxt == per_q) begin
              meas_d  = count_q;
              state_d = S_DONE;
            end
          end else if (idle_tc) begin
            meas_d    = '0;
            result_ev = 1'b1;
            result    = ST_TIMEOUT;
            state_d   = S_ARM;
            arm_load  = 1'b1;
          end
        end
      end
      S_DONE: begin
        result_ev = 1'b1;
        result    = grade;
        state_d   = enable ? S_ARM : S_IDLE;
        arm_load  = enable;
      end
      default: state_d = S_IDLE;
    endcase

    if (arm_load) begin
      per_d = (periods == 8'd0) ? 8'd1 : periods;
      exp_d = expected;
      tol_d = CNT_W'(tolerance);
    end

    // A result is visible for the valid cycle; otherwise show activity or the last result.
    if (result_ev) begin
      valid_d    = 1'b1;
      status_d   = result;
      last_res_d = result;
    end else if (state_d == S_IDLE) begin
      status_d = last_res_q;
    end else begin
      status_d = ST_MEASURING;
    end
  end

  always_comb begin
    idle_d = idle_q - TO_W'(1);
    if (!idle_run || rise || arm_load) idle_d = TO_LOAD;
  end

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      edges_q    <= '0;
      per_q      <= '0;
      exp_q      <= '0;
      tol_q      <= '0;
      idle_q     <= '0;
      meas_q     <= '0;
      valid_q    <= 1'b0;
      status_q   <= ST_IDLE;
      last_res_q <= ST_IDLE;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      edges_q    <= edges_d;
      per_q      <= per_d;
      exp_q      <= exp_d;
      tol_q      <= tol_d;
      idle_q     <= idle_d;
      meas_q     <= meas_d;
      valid_q    <= valid_d;
      status_q   <= status_d;
      last_res_q <= last_res_d;
    end
  end

  assign measured = meas_q;
  assign valid    = valid_q;
  assign status   = status_q;

`ifdef CLK_METER_MINMAX_EN
  logic [CNT_W-1:0] min_q, max_q, last_q, prd;
  logic             en_q;

  // Count at the previous rise; the arming rise corresponds to count 0.
  assign prd = count_q - last_q;

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      min_q  <= '1;
      max_q  <= '0;
      last_q <= '0;
      en_q   <= 1'b0;
    end else begin
      en_q <= enable;
      if (enable && !en_q) begin
        min_q <= '1;
        max_q <= '0;
      end else if ((state_q == S_COUNT) && rise) begin
        if (prd < min_q) min_q <= prd;
        if (prd > max_q) max_q <= prd;
      end
      if ((state_q == S_ARM) && rise)        last_q <= '0;
      else if ((state_q == S_COUNT) && rise) last_q <= count_q;
    end
  end

  assign min_period = min_q;
  assign max_period = max_q;
`endif

endmodule

// File: doc/clk_meter.md
Name: clk_meter

Overview:
- Measures a divided clock or lock-indicator signal (`meas_in`) against `ref_clk`; this is the receive/check side of the CLOCK generator.
- Counts `ref_clk` cycles spanning a programmable number of `meas_in` periods.
- Compares the count with an expected value and tolerance, then reports measured count and lock status.
- Sits beside the CLOCK generator for closed-loop checking and self-test.

Parameters:
- CNT_W, 32, width of measured/expected counters
- SYNC_STAGES, 2, synchroniser flops on `meas_in` (min 2)
- TIMEOUT_CYCLES, 65536, ref cycles without a `meas_in` edge before TIMEOUT

Ports:
- ref_clk  input  1  sole clock, rising edge
- reset  input  1  synchronous, active-high
- enable  input  1  level; 1 = run measurements back-to-back, 0 = return to IDLE
- meas_in  input  1  asynchronous measured signal; period must be >= 4 ref_clk cycles
- periods  input  8  number of `meas_in` periods per measurement; 0 treated as 1
- expected  input  CNT_W  expected ref_clk count per measurement
- tolerance  input  16  allowed absolute deviation, zero-extended to CNT_W
- measured  output  CNT_W  last completed count
- valid  output  1  one-cycle pulse when `measured`/`status` update
- status  output  3  0 IDLE, 1 MEASURING, 2 LOCKED, 3 SLOW, 4 FAST, 5 TIMEOUT, 6 OVERFLOW

Behaviour:
- Reset: `measured`=0, `valid`=0, `status`=0, FSM=IDLE, counters=0, sync chain=0.
- Edge detect: `meas_in` passes SYNC_STAGES flops plus one delay flop. `rise` = synced & ~delayed. Edge-to-`rise` latency is SYNC_STAGES+1 cycles.
- `periods`, `expected` and `tolerance` are captured on ARM entry. Changes mid-measurement take effect on the next measurement.
- FSM IDLE: `status` holds its last result value; 0 after reset. Goes to ARM when `enable`=1.
- FSM ARM: `status`=1. Waits for `rise`. On `rise`: count=1, edges=0, go to COUNT.
- FSM COUNT: count += 1 every cycle. On `rise`, edges += 1. When edges reaches `periods`, `measured` = count value before the increment (exactly periods × period in ref cycles) and go to DONE.
- FSM DONE (1 cycle): `valid`=1. Compare d = `measured` − `expected`:
  - |d| <= tol → LOCKED
  - measured > expected+tol → SLOW
  - measured < expected−tol → FAST
- After DONE: go to ARM if `enable`=1, else IDLE. The `rise` that ended the measurement is not reused; ARM waits for the next edge.
- Comparison arithmetic is CNT_W+1 bits, so `expected`+`tolerance` never wraps.
- Timeout: an idle counter resets on every `rise`. If it reaches TIMEOUT_CYCLES in ARM or COUNT: `measured`=0, `valid` pulse, `status`=5, go to ARM.
- Overflow: count saturating at all-ones in COUNT gives `measured`=all-ones, `valid` pulse, `status`=6, go to ARM.
- Precedence when several events land in the same cycle: reset > overflow > periods-complete > timeout.
- `enable` deasserted mid-measurement: abort next cycle to IDLE, no `valid`, `status` keeps its previous result.
- `reset` mid-measurement: everything returns to its reset values next edge.

Optional Feature:
- Macro: CLK_METER_MINMAX_EN.
- Defined:
  - Adds outputs `min_period` and `max_period` (CNT_W each) recording the shortest and longest single `meas_in` period seen since reset, or since `enable` rose.
  - Reset values: min = all-ones, max = 0.
  - Updated on every `rise` in COUNT.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package `clk_meter_pkg`:
  - status encoding as typedef enum logic [2:0] (ST_IDLE..ST_OVERFLOW)
  - FSM state enum (S_IDLE, S_ARM, S_COUNT, S_DONE)
  - default CNT_W constant
- One sub-module, `clk_meter_sync_edge`: SYNC_STAGES synchroniser plus rising-edge pulse, reused elsewhere for async inputs.

Test Plan:
- `meas_in` period 20 cycles, periods=10, expected=200, tol=2 → `measured`=200, `status`=2, `valid` once per measurement.
- Period 21, periods=10, expected=200, tol=5 → `measured`=210, `status`=3 (SLOW); period 19 → 190, `status`=4 (FAST).
- `meas_in` held 0, TIMEOUT_CYCLES=1000 → `valid` with `measured`=0, `status`=5, about 1000 cycles after ARM entry.
- `enable` dropped after 3 of 10 periods → no `valid`, FSM IDLE, `status` unchanged. Re-enable → fresh 200 result.
- Synchronous `reset` pulse during COUNT → all outputs 0 next cycle, no `valid`.
- CLK_METER_MINMAX_EN with alternating periods 18/22 → `min_period`=18, `max_period`=22, `measured`=200 for periods=10.
